// File: rtl/ota_sd_stim_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ota_sd_stim_tx_if
// Description : Load handshake and differential bitstream bundle for the
//               OTA sigma-delta stimulus transmitter.
//               master : code source / observer (bench or firmware side)
//               slave  : the transmitter itself
//   din        : unsigned code offered for modulation (master -> slave)
//   din_valid  : code offered                         (master -> slave)
//   din_ready  : transmitter can take a code          (slave  -> master)
//   vip_out    : positive bitstream                   (slave  -> master)
//   vin_out    : negative bitstream                   (slave  -> master)
//   busy       : frame data on the outputs            (slave  -> master)
//   frame_done : end of the last repeat of a code     (slave  -> master)
// Revision    : 1.0  initial release
// ============================================================================
interface ota_sd_stim_tx_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             vip_out;
   logic             vin_out;
   logic             busy;
   logic             frame_done;

   modport master (
      output din,
      output din_valid,
      input  din_ready,
      input  vip_out,
      input  vin_out,
      input  busy,
      input  frame_done
   );

   modport slave (
      input  din,
      input  din_valid,
      output din_ready,
      output vip_out,
      output vin_out,
      output busy,
      output frame_done
   );
endinterface
`default_nettype wire

// File: rtl/ota_sd_stim_tx.sv
`default_nettype none
// ============================================================================
// Module      : ota_sd_stim_tx
// Description : First-order sigma-delta stimulus transmitter. A loaded code
//               is turned into a complementary bitstream whose positive leg is
//               high for exactly `code` cycles out of every 2^WIDTH cycle
//               frame, repeated REPEAT times per accepted code.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               ena    - clock enable, low freezes the whole block
//               sd     - ota_sd_stim_tx_if.slave (code handshake + outputs)
// Revision    : 1.0  initial release
// ============================================================================
module ota_sd_stim_tx #(
   parameter int WIDTH  = 8,
   parameter int REPEAT = 1
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          ena,
   ota_sd_stim_tx_if.slave    sd
);

   localparam int c_REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT - 1);
   localparam logic [WIDTH-1:0]   c_CNT_LAST = {WIDTH{1'b1}};

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              state_q;
   logic [WIDTH-1:0]    code_q;
   logic [WIDTH-1:0]    acc_q;
   logic [WIDTH-1:0]    cnt_q;
   logic [c_REP_W-1:0]  rep_q;
   logic                vip_q;
   logic                vin_q;
   logic                busy_q;
   logic                frame_done_q;

   logic [WIDTH:0]      sum_d;
   logic                w_cnt_last;
   logic                w_rep_last;
   logic                w_frame_last;
   logic                w_ready;
   logic                w_accept;

   // Accumulator sum: the carry out is the bit emitted this cycle.
   assign sum_d        = {1'b0, acc_q} + {1'b0, code_q};
   assign w_cnt_last   = (cnt_q == c_CNT_LAST);
   assign w_rep_last   = (rep_q == c_REP_LAST);
   assign w_frame_last = (state_q == S_RUN) && w_cnt_last && w_rep_last;

   // Ready looks only at state, never at din_valid, so a new code can be
   // taken on the closing edge of the final repeat without an idle cycle.
   assign w_ready  = ena && ((state_q == S_IDLE) || w_frame_last);
   assign w_accept = w_ready && sd.din_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         code_q       <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         rep_q        <= '0;
         vip_q        <= 1'b0;
         vin_q        <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else if (ena) begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               // Zero differential while idle.
               vip_q  <= 1'b0;
               vin_q  <= 1'b0;
               busy_q <= 1'b0;
               if (w_accept) begin
                  code_q  <= sd.din;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  rep_q   <= '0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               acc_q  <= sum_d[WIDTH-1:0];
               vip_q  <= sum_d[WIDTH];
               vin_q  <= ~sum_d[WIDTH];
               busy_q <= 1'b1;
               cnt_q  <= cnt_q + 1'b1;
               if (w_cnt_last) begin
                  if (!w_rep_last) begin
                     rep_q <= rep_q + 1'b1;
                  end else begin
                     frame_done_q <= 1'b1;
                     if (w_accept) begin
                        // Back-to-back load: acc already returns to zero at
                        // the frame end, the explicit clears keep it obvious.
                        code_q <= sd.din;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        rep_q  <= '0;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end else begin
         // Frozen: everything holds except the end-of-frame pulse.
         frame_done_q <= 1'b0;
      end
   end

   assign sd.din_ready  = w_ready;
   assign sd.vip_out    = vip_q;
   assign sd.vin_out    = vin_q;
   assign sd.busy       = busy_q;
   assign sd.frame_done = frame_done_q;

endmodule
`default_nettype wire
